// File: rtl/vga_fb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the framebuffer arbiter slice.
//   H_ACTIVE / V_ACTIVE / FB_PIXELS : default visible frame geometry
//   DATA_W / ADDR_W                 : default pixel and framebuffer address widths
//   pixel_t                         : one RGB888 pixel
//   fetch_state_t                   : refresh fetch progress within a frame
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned FB_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int unsigned DATA_W    = 24;
    localparam int unsigned ADDR_W    = 19;

    typedef logic [DATA_W-1:0] pixel_t;

    // IDLE  : no frame_start seen yet
    // FETCH : prefetching pixels of the current frame
    // DONE  : every pixel address of the frame has been issued
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    // True when an address width can reach every pixel of a frame.
    function automatic bit addr_fits(input int unsigned aw, input int unsigned pixels);
        return (64'd1 << aw) >= 64'(pixels);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces used by vga_fb_arbiter.
//
// vga_wr_if : pixel writer port.
//   valid, addr, data : from writer (master)
//   ready             : from arbiter (slave)
//   Handshake: a write transfers in every cycle where valid && ready are both
//   high. ready is combinational and may depend on valid in the same cycle;
//   the writer must hold addr/data stable while valid is high and not yet
//   accepted.
//
// vga_mem_if : single-port framebuffer RAM bus.
//   addr, re, we, wdata : from arbiter (master)
//   rdata               : from RAM (slave), valid exactly one cycle after re
// -----------------------------------------------------------------------------
interface vga_wr_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 24
) ();
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output addr, output data, input  ready);
    modport slave  (input  valid, input  addr, input  data, output ready);
endinterface

interface vga_mem_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 24
) ();
    logic [ADDR_W-1:0] addr;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output re, output we, output wdata, input  rdata);
    modport slave  (input  addr, input  re, input  we, input  wdata, output rdata);
endinterface

// File: rtl/vga_fb_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// vga_pix_fifo
// Synchronous prefetch FIFO for display pixels.
//   clock, reset : pixel clock, asynchronous active-high reset
//   flush        : empties the FIFO; wins over push/pop in the same cycle
//   push, push_data : write one entry
//   pop          : drop the head entry (ignored when empty)
//   head         : current head entry (combinational read)
//   count        : occupancy, 0..FIFO_DEPTH
//   empty        : count == 0
// Push and pop may occur together at any occupancy, including full.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module vga_pix_fifo #(
    parameter  int unsigned FIFO_DEPTH = 16,
    parameter  int unsigned DATA_W     = 24,
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    logic [DATA_W-1:0] store [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between display refresh (prefetching
// into a small FIFO feeding the RGB path) and a pixel writer.
//   clock, reset : pixel clock, asynchronous active-high reset
//   frame_start  : pulse one line before the first visible pixel; restarts the
//                  frame fetch from address 0 and flushes the FIFO
//   pix_req      : pop request, one cycle ahead of dataEnable
//   pix_data     : registered pixel (0 on underflow)
//   pix_valid    : pix_data updated this cycle
//   underflow    : sticky, set when a pop finds the FIFO empty
//   wr           : writer port (vga_wr_if.slave), ready is combinational
//   mem          : RAM port (vga_mem_if.master), rdata one cycle after re
//   dbg_state    : current fetch state
//   dbg_count    : current FIFO occupancy
// Refresh takes the RAM when its reservation (occupancy + read in flight) is
// below LOW_WATER, or whenever it has room and the writer is idle.
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int unsigned DATA_W     = vga_pkg::DATA_W,
    parameter int unsigned ADDR_W     = vga_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LOW_WATER  = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic                        pix_req,
    output logic [DATA_W-1:0]           pix_data,
    output logic                        pix_valid,
    output logic                        underflow,
    vga_wr_if.slave                     wr,
    vga_mem_if.master                   mem,
    output vga_pkg::fetch_state_t       dbg_state,
    output logic [$clog2(FIFO_DEPTH):0] dbg_count
);

    import vga_pkg::*;

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RES_W   = CNT_W + 1;
    localparam int unsigned FB_PIX  = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIX - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_addr;
    logic              inflight;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic [DATA_W-1:0] head;

    logic [RES_W-1:0]  reserved;
    logic              eligible;
    logic              urgent;
    logic              refresh_win;
    logic              write_win;
    logic              pop_req;
    logic              fifo_push;

    // Reserving the in-flight slot keeps a returning read from ever finding
    // the FIFO full.
    assign reserved = {1'b0, count} + RES_W'(inflight);

    // No new fetch is started in a frame_start cycle: fetch_addr is about to be
    // rewound, so such a read would be for the wrong frame anyway.
    assign eligible = (state == S_FETCH) && !frame_start
                      && (reserved < RES_W'(FIFO_DEPTH));
    assign urgent   = reserved < RES_W'(LOW_WATER);

    // Both strobes are masked during reset so the RAM sees nothing while the
    // block is being cleared.
    assign refresh_win = !reset && eligible && (urgent || !wr.valid);
    assign write_win   = !reset && !refresh_win && wr.valid;

    assign wr.ready  = write_win;
    assign mem.re    = refresh_win;
    assign mem.we    = write_win;
    assign mem.addr  = refresh_win ? fetch_addr : wr.addr;
    assign mem.wdata = wr.data;

    // Requests coinciding with frame_start are dropped; the FIFO is flushing.
    assign pop_req   = pix_req && !frame_start;
    // Data from a read issued before frame_start belongs to the old frame.
    assign fifo_push = inflight && !frame_start;

    assign dbg_state = fetch_state_t'(state);
    assign dbg_count = count;

    vga_pix_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (frame_start),
        .push      (fifo_push),
        .push_data (mem.rdata),
        .pop       (pop_req),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    // Fetch sequencing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            fetch_addr <= '0;
            inflight   <= 1'b0;
        end else if (frame_start) begin
            state      <= S_FETCH;
            fetch_addr <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= refresh_win;
            if (refresh_win) begin
                fetch_addr <= fetch_addr + ADDR_W'(1);
                if (fetch_addr == LAST_ADDR) begin
                    state <= S_DONE;
                end
            end
        end
    end

    // Pixel output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_data  <= '0;
            pix_valid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pix_valid <= pop_req;
            if (pop_req) begin
                pix_data <= empty ? '0 : head;
                if (empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
// Bench for vga_fb_arbiter with a small 8x4 frame so a whole frame fits in a
// short run. A behavioural RAM answers reads one cycle after mem_re. The bench
// keeps its own copy of what the framebuffer should hold (gold) and pushes the
// pixel it expects on every accepted pop into exp_q; a monitor pops and
// compares whenever pix_valid is seen.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int unsigned TH   = 8;
    localparam int unsigned TV   = 4;
    localparam int unsigned TPIX = TH * TV;
    localparam int unsigned AW   = 19;
    localparam int unsigned DW   = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          pix_req;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          underflow;
    fetch_state_t  dbg_state;
    logic [4:0]    dbg_count;

    vga_wr_if  #(.ADDR_W(AW), .DATA_W(DW)) wr ();
    vga_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    vga_fb_arbiter #(
        .H_ACTIVE   (TH),
        .V_ACTIVE   (TV),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (16),
        .LOW_WATER  (8)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .wr          (wr),
        .mem         (mem),
        .dbg_state   (dbg_state),
        .dbg_count   (dbg_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    function automatic pixel_t pat(input int i);
        return {8'(i), 8'(8'h5A ^ 8'(i)), 8'(i * 3 + 1)};
    endfunction

    pixel_t     ram [64];
    logic [63:0] wmask = '0;

    always @(posedge clk) begin
        if (mem.we) begin
            ram[mem.addr[5:0]]   <= mem.wdata;
            wmask[mem.addr[5:0]] <= 1'b1;
        end
        if (mem.re) begin
            mem.rdata <= wmask[mem.addr[5:0]] ? ram[mem.addr[5:0]] : pat(int'(mem.addr[5:0]));
        end
    end

    // ---------------- scoreboard ----------------
    int            total = 0;
    int            bad   = 0;
    int            clash = 0;
    logic [DW-1:0] exp_q [$];
    pixel_t        gold  [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem.re && mem.we) clash++;
        if (pix_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_pix_valid: got pix_valid=1 expected 0 (t=%0t)", $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                total--;
                chk("pix_data", pix_data, e);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          e_ready;
        logic          e_we;
    } wvec_t;

    wvec_t tbl [4];

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: got timeout expected test completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 64; i++) gold[i] = pat(i);

        tbl[0] = '{v: 1'b1, a: 19'd5,  d: 24'hABCDEF, e_ready: 1'b1, e_we: 1'b1};
        tbl[1] = '{v: 1'b0, a: 19'd9,  d: 24'h111111, e_ready: 1'b0, e_we: 1'b0};
        tbl[2] = '{v: 1'b1, a: 19'd33, d: 24'h00FF00, e_ready: 1'b1, e_we: 1'b1};
        tbl[3] = '{v: 1'b1, a: 19'd20, d: 24'h0F0F0F, e_ready: 1'b1, e_we: 1'b1};

        // Reset with a writer pushing: nothing may reach the RAM.
        rst = 1'b1; frame_start = 1'b0; pix_req = 1'b0;
        wr.valid = 1'b1; wr.addr = 19'd5; wr.data = 24'h123456;
        repeat (2) @(posedge clk);
        at_neg();
        chk("rst_pix_data",  pix_data, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_mem_re",    mem.re, 0);
        chk("rst_mem_we",    mem.we, 0);
        chk("rst_wr_ready",  wr.ready, 0);
        chk("rst_state",     32'(dbg_state), 32'(IDLE));
        chk("rst_count",     dbg_count, 0);
        wr.valid = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        at_neg();
        chk("idle_mem_re",    mem.re, 0);
        chk("idle_pix_valid", pix_valid, 0);
        chk("idle_state",     32'(dbg_state), 32'(IDLE));

        // Writer table in IDLE: granted whenever valid, same cycle.
        for (int i = 0; i < 4; i++) begin
            step();
            wr.valid = tbl[i].v; wr.addr = tbl[i].a; wr.data = tbl[i].d;
            at_neg();
            chk("tbl_wr_ready", wr.ready, tbl[i].e_ready);
            chk("tbl_mem_we",   mem.we,   tbl[i].e_we);
            chk("tbl_mem_re",   mem.re,   0);
            if (tbl[i].v) begin
                chk("tbl_mem_addr",  mem.addr,  tbl[i].a);
                chk("tbl_mem_wdata", mem.wdata, tbl[i].d);
                if (tbl[i].a < 64) gold[tbl[i].a[5:0]] = tbl[i].d;
            end
        end
        step();
        wr.valid = 1'b0;

        // Frame 1: plain fill of 16, then read the whole frame back.
        frame_start = 1'b1;
        at_neg();
        chk("fs_no_re", mem.re, 0);
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            at_neg();
            chk("fill_re",   mem.re, 1);
            chk("fill_addr", mem.addr, i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("full_no_re", mem.re, 0);
            step();
        end
        chk("full_count", dbg_count, 16);
        chk("full_state", 32'(dbg_state), 32'(FETCH));
        for (int k = 0; k < int'(TPIX); k++) begin
            pix_req = 1'b1;
            exp_q.push_back(gold[k]);
            step();
        end
        pix_req = 1'b0;
        repeat (3) step();
        chk("frame_done_state", 32'(dbg_state), 32'(DONE));
        chk("frame_underflow",  underflow, 0);
        chk("frame_drained",    exp_q.size(), 0);

        // Frame 2: writer held valid during the fill.
        wr.valid = 1'b1; wr.addr = 19'd40; wr.data = 24'h404040;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            chk("urgent_wr_ready", wr.ready, 0);
            chk("urgent_re",       mem.re, 1);
            chk("urgent_addr",     mem.addr, i);
            step();
        end
        for (int j = 0; j < 4; j++) begin
            at_neg();
            chk("wr_grant_ready", wr.ready, 1);
            chk("wr_grant_we",    mem.we, 1);
            chk("wr_grant_re",    mem.re, 0);
            chk("wr_grant_addr",  mem.addr, 40 + j);
            step();
            wr.addr = 19'(41 + j); wr.data = 24'(24'h404041 + j);
        end
        chk("wr_hold_count", dbg_count, 8);
        wr.valid = 1'b0;
        repeat (12) step();

        // Frame 3: request ignored on frame_start, then an underflow.
        frame_start = 1'b1; pix_req = 1'b1;
        step();
        frame_start = 1'b0; pix_req = 1'b1;
        at_neg();
        chk("fs_req_ignored", pix_valid, 0);
        exp_q.push_back('0);
        step();
        pix_req = 1'b0;
        at_neg();
        chk("uf_pix_valid", pix_valid, 1);
        chk("uf_set",       underflow, 1);
        repeat (3) step();

        // Frame 4: restart while a read is in flight.
        frame_start = 1'b1;
        at_neg();
        chk("restart_no_re", mem.re, 0);
        step();
        frame_start = 1'b0;
        at_neg();
        chk("restart_re",     mem.re, 1);
        chk("restart_addr",   mem.addr, 0);
        chk("restart_count",  dbg_count, 0);
        chk("uf_sticky",      underflow, 1);
        repeat (20) step();
        for (int k = 0; k < 6; k++) begin
            pix_req = 1'b1;
            exp_q.push_back(gold[k]);
            step();
        end

        // Reset in the middle of the frame, with a pixel on the output.
        pix_req = 1'b1;
        exp_q.push_back(gold[6]);
        step();
        pix_req = 1'b0;
        wr.valid = 1'b1; wr.addr = 19'd50;
        at_neg();
        #1 rst = 1'b1;
        #1;
        chk("async_pix_valid", pix_valid, 0);
        chk("async_pix_data",  pix_data, 0);
        chk("async_underflow", underflow, 0);
        chk("async_mem_re",    mem.re, 0);
        chk("async_mem_we",    mem.we, 0);
        chk("async_count",     dbg_count, 0);
        chk("async_state",     32'(dbg_state), 32'(IDLE));
        repeat (2) step();
        at_neg();
        rst = 1'b0;
        wr.valid = 1'b0;
        repeat (2) step();

        chk("strobe_clash",  clash, 0);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
